mem_port_arbiter: RTL

//  Shares one single-ported memory between instruction fetch (IFU) and load/store (LSU).

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mux2.sv | 13 +
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and owner codes.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   localparam logic OWNER_IFU = 1'b0;
   localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the arbiter.
// master = arbiter side, slave = requesters plus memory wrapper.
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  ifu_req;
   logic [ADDR_WIDTH-1:0] ifu_addr;
   logic                  ifu_done;
   logic [DATA_WIDTH-1:0] ifu_rdata;

   logic                  lsu_req;
   logic                  lsu_we;
   logic [ADDR_WIDTH-1:0] lsu_addr;
   logic [DATA_WIDTH-1:0] lsu_wdata;
   logic                  lsu_done;
   logic [DATA_WIDTH-1:0] lsu_rdata;

   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ready;

   logic                  grant_lsu;

   modport master (
      input  ifu_req, ifu_addr,
      output ifu_done, ifu_rdata,
      input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
      output lsu_done, lsu_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready,
      output grant_lsu
   );

   modport slave (
      output ifu_req, ifu_addr,
      input  ifu_done, ifu_rdata,
      output lsu_req, lsu_we, lsu_addr, lsu_wdata,
      input  lsu_done, lsu_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready,
      input  grant_lsu
   );

endinterface

// File: rtl/mux2.sv
// Generic two-input mux shared across the datapath: sel=1 picks a, sel=0 picks b.
module mux2 #(
   parameter int WIDTH = 32
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   assign y = sel ? a : b;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store, one transaction at a time.
// Build option MEM_ARB_RR_EN: round-robin on simultaneous requests instead of fixed LSU priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.master bus
);

   arb_state_e            state_q, state_d;
   logic                  grant_q, grant_d;
   logic [DATA_WIDTH-1:0] ifu_rdata_q, ifu_rdata_d;
   logic [DATA_WIDTH-1:0] lsu_rdata_q, lsu_rdata_d;
   logic                  winner;

`ifdef MEM_ARB_RR_EN
   logic last_grant_q, last_grant_d;

   // On a tie the side that was not granted most recently wins.
   always_comb begin
      winner = bus.lsu_req ? OWNER_LSU : OWNER_IFU;
      if (bus.ifu_req && bus.lsu_req) begin
         winner = ~last_grant_q;
      end
   end
`else
   always_comb begin
      winner = bus.lsu_req ? OWNER_LSU : OWNER_IFU;
   end
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ifu_rdata_d = ifu_rdata_q;
      lsu_rdata_d = lsu_rdata_q;
`ifdef MEM_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.ifu_req || bus.lsu_req) begin
               grant_d = winner;
               state_d = ST_BUSY;
`ifdef MEM_ARB_RR_EN
               last_grant_d = winner;
`endif
            end
         end
         ST_BUSY: begin
            if (bus.mem_ready) begin
               if (grant_q == OWNER_LSU) begin
                  lsu_rdata_d = bus.mem_rdata;
               end else begin
                  ifu_rdata_d = bus.mem_rdata;
               end
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         grant_q     <= OWNER_IFU;
         ifu_rdata_q <= '0;
         lsu_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
         last_grant_q <= OWNER_IFU;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ifu_rdata_q <= ifu_rdata_d;
         lsu_rdata_q <= lsu_rdata_d;
`ifdef MEM_ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   // Strobes decode straight from the state flop so a reset drops them in the same cycle.
   assign bus.mem_req   = (state_q == ST_BUSY);
   assign bus.mem_we    = (state_q == ST_BUSY) && (grant_q == OWNER_LSU) && bus.lsu_we;
   assign bus.ifu_done  = (state_q == ST_RESP) && (grant_q == OWNER_IFU);
   assign bus.lsu_done  = (state_q == ST_RESP) && (grant_q == OWNER_LSU);
   assign bus.grant_lsu = grant_q;
   assign bus.ifu_rdata = ifu_rdata_q;
   assign bus.lsu_rdata = lsu_rdata_q;

   mux2 #(.WIDTH(ADDR_WIDTH)) u_addr_mux (
      .sel (grant_q),
      .a   (bus.lsu_addr),
      .b   (bus.ifu_addr),
      .y   (bus.mem_addr)
   );

   mux2 #(.WIDTH(DATA_WIDTH)) u_wdata_mux (
      .sel (grant_q),
      .a   (bus.lsu_wdata),
      .b   ({DATA_WIDTH{1'b0}}),
      .y   (bus.mem_wdata)
   );

endmodule
